// File: rtl/clk_switch_pkg.sv
// Shared types and defaults for the clock-switch controller.
package clk_switch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SWITCH,
        SETTLE,
        ABORT,
        FAULT
    } state_t;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int SETTLE_CYCLES_DEF  = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // The mux reports "clk0 active"; clk1 counts as reached when that flag is low.
    function automatic logic sel_reached(input logic target, input logic ack);
        return target ? ~ack : ack;
    endfunction

endpackage

// File: rtl/clk_switch_sync.sv
// Multi-flop synchroniser for the mux's asynchronous status line.
module clk_switch_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] stage_reg;
    logic [STAGES-1:0] stage_next;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = d_i;
            end else begin : g_chain
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    // Shift the status bit through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q_o = stage_reg[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-mux switch controller: requests a new select, waits for the mux to
// confirm it for a settle window, reverts on timeout and latches a fault if
// the revert cannot be confirmed either.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic req_valid_i,
    input  logic req_sel_i,
    output logic req_ready_o,
    output logic rsp_valid_o,
    output logic rsp_err_o,
    output logic sel_o,
    input  logic clk_selected_i,
    output logic cur_sel_o,
    output logic busy_o,
    output logic fault_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMER_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  timer_reg, timer_next, timer_inc;
    logic [SET_W-1:0]  settle_reg, settle_next;
    logic              sel_reg, sel_next;
    logic              cur_sel_reg, cur_sel_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              ack;
    logic              target_met;
    logic              timed_out;

    clk_switch_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (clk_selected_i),
        .q_o    (ack)
    );

    // Timer saturates so it can never wrap back under the timeout threshold.
    assign timer_inc  = (timer_reg < TIMER_MAX) ? timer_reg + 1'b1 : timer_reg;
    assign timed_out  = (timer_reg == TIMER_LAST);
    // In ABORT sel_reg already holds cur_sel_reg, so one target serves every state.
    assign target_met = sel_reached(sel_reg, ack);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            settle_reg    <= '0;
            sel_reg       <= 1'b0;
            cur_sel_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            settle_reg    <= settle_next;
            sel_reg       <= sel_next;
            cur_sel_reg   <= cur_sel_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Next-state logic: timeout takes priority over the settle condition.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        settle_next    = settle_reg;
        sel_next       = sel_reg;
        cur_sel_next   = cur_sel_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_sel_i == cur_sel_reg) begin
                        rsp_valid_next = 1'b1;
                    end else begin
                        sel_next    = req_sel_i;
                        timer_next  = '0;
                        settle_next = '0;
                        state_next  = SWITCH;
                    end
                end
            end
            SWITCH, SETTLE: begin
                timer_next = timer_inc;
                if (timed_out) begin
                    sel_next    = cur_sel_reg;
                    timer_next  = '0;
                    settle_next = '0;
                    state_next  = ABORT;
                end else if (!target_met) begin
                    settle_next = '0;
                    state_next  = SWITCH;
                end else if (settle_reg == SETTLE_LAST) begin
                    cur_sel_next   = sel_reg;
                    rsp_valid_next = 1'b1;
                    settle_next    = '0;
                    state_next     = IDLE;
                end else begin
                    settle_next = settle_reg + 1'b1;
                    state_next  = SETTLE;
                end
            end
            ABORT: begin
                timer_next = timer_inc;
                if (timed_out) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    state_next     = FAULT;
                end else if (!target_met) begin
                    settle_next = '0;
                end else if (settle_reg == SETTLE_LAST) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    settle_next    = '0;
                    state_next     = IDLE;
                end else begin
                    settle_next = settle_reg + 1'b1;
                end
            end
            FAULT: begin
                sel_next = cur_sel_reg;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_reg == IDLE);
    assign busy_o      = (state_reg != IDLE);
    assign fault_o     = (state_reg == FAULT);
    assign sel_o       = sel_reg;
    assign cur_sel_o   = cur_sel_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with a cycle-level behavioural model.
module tb_clk_switch_ctrl;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 1024;
    localparam int SYNC    = 2;
    localparam int D       = 5;
    localparam int HIST    = 8192;

    localparam int P_IDLE   = 0;
    localparam int P_MOVE   = 1;
    localparam int P_REVERT = 2;
    localparam int P_FAULT  = 3;

    localparam int MUX_NORMAL = 0;
    localparam int MUX_STUCK1 = 1;
    localparam int MUX_STUCK0 = 2;

    logic clk_i = 1'b0;
    logic rstn_i;
    logic req_valid_i;
    logic req_sel_i;
    logic req_ready_o;
    logic rsp_valid_o;
    logic rsp_err_o;
    logic sel_o;
    logic clk_selected_i;
    logic cur_sel_o;
    logic busy_o;
    logic fault_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    clk_switch_ctrl dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (req_valid_i),
        .req_sel_i      (req_sel_i),
        .req_ready_o    (req_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_err_o      (rsp_err_o),
        .sel_o          (sel_o),
        .clk_selected_i (clk_selected_i),
        .cur_sel_o      (cur_sel_o),
        .busy_o         (busy_o),
        .fault_o        (fault_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- mux model ----------------
    logic sel_hist [0:HIST-1];
    int   mux_mode   = MUX_NORMAL;
    int   glitch_cyc = -1;

    always @(negedge clk_i) sel_hist[cyc % HIST] <= sel_o;

    function automatic logic mux_value();
        logic v;
        case (mux_mode)
            MUX_STUCK1: v = 1'b1;
            MUX_STUCK0: v = 1'b0;
            default:    v = (cyc >= D) ? ~sel_hist[(cyc - D) % HIST] : 1'b1;
        endcase
        if (cyc == glitch_cyc) v = ~v;
        return v;
    endfunction

    initial begin
        clk_selected_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            clk_selected_i = mux_value();
        end
    end

    // ---------------- behavioural model ----------------
    int   m_phase = P_IDLE;
    logic m_sel   = 1'b0;
    logic m_cur   = 1'b0;
    logic m_rsp   = 1'b0;
    logic m_err   = 1'b0;
    int   elapsed = 0;
    int   run     = 0;
    logic ack_pipe [SYNC];

    task automatic model_reset();
        m_phase = P_IDLE;
        m_sel   = 1'b0;
        m_cur   = 1'b0;
        m_rsp   = 1'b0;
        m_err   = 1'b0;
        elapsed = 0;
        run     = 0;
        for (int i = 0; i < SYNC; i++) ack_pipe[i] = 1'b0;
    endtask

    task automatic model_step();
        logic a;
        logic met;
        a = ack_pipe[0];
        for (int i = 0; i < SYNC - 1; i++) ack_pipe[i] = ack_pipe[i+1];
        ack_pipe[SYNC-1] = clk_selected_i;
        m_rsp = 1'b0;
        m_err = 1'b0;
        if (m_phase == P_IDLE) begin
            if (req_valid_i) begin
                if (req_sel_i == m_cur) begin
                    m_rsp = 1'b1;
                end else begin
                    m_sel   = req_sel_i;
                    m_phase = P_MOVE;
                    elapsed = 0;
                    run     = 0;
                end
            end
        end else if (m_phase == P_MOVE || m_phase == P_REVERT) begin
            met = (m_sel == 1'b0) ? a : ~a;
            if (elapsed == TIMEOUT - 1) begin
                if (m_phase == P_MOVE) begin
                    m_sel   = m_cur;
                    m_phase = P_REVERT;
                    elapsed = 0;
                    run     = 0;
                end else begin
                    m_phase = P_FAULT;
                    m_rsp   = 1'b1;
                    m_err   = 1'b1;
                end
            end else begin
                elapsed = elapsed + 1;
                run     = met ? run + 1 : 0;
                if (run == SETTLE) begin
                    m_err   = (m_phase == P_REVERT);
                    m_rsp   = 1'b1;
                    m_cur   = m_sel;
                    m_phase = P_IDLE;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) model_reset();
            else         model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [6:0] act;
        logic [6:0] exp;
        forever begin
            @(negedge clk_i);
            exp = {m_sel, m_cur, m_phase == P_IDLE, m_phase != P_IDLE,
                   m_phase == P_FAULT, m_rsp, m_err};
            act = {sel_o, cur_sel_o, req_ready_o, busy_o, fault_o,
                   rsp_valid_o, rsp_err_o & rsp_valid_o};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d {sel,cur,ready,busy,fault,rsp,err} got=%b want=%b",
                         cyc, act, exp);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic handshake(input logic s, output int t);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b1;
        req_sel_i   = s;
        t = cyc;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int at, output int err, output int busy_n);
        at = -1;
        err = -1;
        busy_n = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                at  = cyc;
                err = rsp_err_o;
                break;
            end
            if (busy_o) busy_n++;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait got=none want=rsp_valid within %0d cycles", max);
        end
    endtask

    task automatic wait_sel(input logic v, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (sel_o == v) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL sel_wait got=none want=sel_o==%0d within %0d cycles", v, max);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int t, at, err, bn, nrsp;
        rstn_i      = 1'b0;
        req_valid_i = 1'b0;
        req_sel_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // idle after reset
        nrsp = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (rsp_valid_o) nrsp++;
        end
        chk("idle_sel", sel_o, 0);
        chk("idle_cur_sel", cur_sel_o, 0);
        chk("idle_ready", req_ready_o, 1);
        chk("idle_fault", fault_o, 0);
        chk("idle_rsp_count", nrsp, 0);

        // clean switch to clk1
        handshake(1'b1, t);
        wait_rsp(100, at, err, bn);
        chk("sw1_latency", at - t, 16);
        chk("sw1_err", err, 0);
        chk("sw1_busy_cycles", bn, 15);
        chk("sw1_cur_sel", cur_sel_o, 1);
        repeat (3) @(negedge clk_i);

        // same-select request
        handshake(1'b1, t);
        wait_rsp(10, at, err, bn);
        chk("same_latency", at - t, 1);
        chk("same_err", err, 0);
        chk("same_sel", sel_o, 1);
        repeat (3) @(negedge clk_i);

        // switch back to clk0 with a one-cycle status glitch mid-settle
        handshake(1'b0, t);
        glitch_cyc = t + 10;
        wait_rsp(100, at, err, bn);
        chk("glitch_latency", at - t, 21);
        chk("glitch_err", err, 0);
        chk("glitch_cur_sel", cur_sel_o, 0);
        glitch_cyc = -1;
        repeat (3) @(negedge clk_i);

        // dead target clock: timeout and successful revert
        mux_mode = MUX_STUCK1;
        handshake(1'b1, t);
        wait_sel(1'b0, 1100, at);
        chk("revert_sel_time", at - t, 1025);
        wait_rsp(100, at, err, bn);
        chk("revert_rsp_time", at - t, 1033);
        chk("revert_err", err, 1);
        chk("revert_cur_sel", cur_sel_o, 0);
        chk("revert_fault", fault_o, 0);
        repeat (3) @(negedge clk_i);

        // revert also fails -> sticky fault
        handshake(1'b1, t);
        wait_sel(1'b0, 1100, at);
        chk("fault_revert_time", at - t, 1025);
        mux_mode = MUX_STUCK0;
        wait_rsp(1100, at, err, bn);
        chk("fault_rsp_time", at - t, 2049);
        chk("fault_err", err, 1);
        chk("fault_flag", fault_o, 1);
        chk("fault_ready", req_ready_o, 0);
        @(posedge clk_i);
        #1 req_valid_i = 1'b1;
        req_sel_i = 1'b1;
        repeat (3) @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("fault_sticky", fault_o, 1);
        chk("fault_busy", busy_o, 1);
        chk("fault_sel_held", sel_o, 0);

        // asynchronous reset clears everything immediately
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_fault", fault_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsp", rsp_valid_o, 0);
        mux_mode = MUX_NORMAL;
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        repeat (10) @(negedge clk_i);

        // reset asserted in the middle of a switch
        handshake(1'b1, t);
        repeat (2) @(negedge clk_i);
        chk("mid_busy", busy_o, 1);
        chk("mid_sel", sel_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("mid_rst_sel", sel_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_cur", cur_sel_o, 0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        repeat (15) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
